// File: rtl/deal_pkg.sv
// Shared types, codes and helpers for the blackjack deal controller.
// Everything that both the game FSM and the card source need to agree on lives here.
package deal_pkg;

    typedef enum logic [2:0] {
        PH_IDLE    = 3'd0,
        PH_CLEAR   = 3'd1,
        PH_DEAL    = 3'd2,
        PH_P1      = 3'd3,
        PH_P2      = 3'd4,
        PH_DEALER  = 3'd5,
        PH_RESOLVE = 3'd6,
        PH_DONE    = 3'd7
    } phase_t;

    typedef enum logic [2:0] {
        XIDLE   = 3'd0,
        XDRAW   = 3'd1,
        XHOLD   = 3'd2,
        XDROP   = 3'd3,
        XSETTLE = 3'd4
    } xfer_t;

    localparam logic [1:0] RES_NONE = 2'd0;
    localparam logic [1:0] RES_WIN  = 2'd1;
    localparam logic [1:0] RES_LOSE = 2'd2;
    localparam logic [1:0] RES_PUSH = 2'd3;

    localparam logic [1:0] SEL_NONE   = 2'd0;
    localparam logic [1:0] SEL_P1     = 2'd1;
    localparam logic [1:0] SEL_P2     = 2'd2;
    localparam logic [1:0] SEL_DEALER = 2'd3;

    localparam logic [4:0] DEALER_STAND = 5'd17;
    localparam logic [4:0] BLACKJACK    = 5'd21;
    localparam logic [2:0] DEAL_CARDS   = 3'd6;
    localparam logic [3:0] MAX_RANK     = 4'd13;
    localparam logic [3:0] FACE_VALUE   = 4'd10;

    // Soft total when it fits, otherwise fall back to the all-aces-low total.
    function automatic logic [4:0] best_total(input logic [4:0] high, input logic [4:0] low);
        if (high <= BLACKJACK)
            return high;
        else if (low != 5'd0)
            return low;
        else
            return high;
    endfunction

    function automatic logic [1:0] resolve_hand(input logic [4:0] player, input logic [4:0] dealer);
        if (player > BLACKJACK)
            return RES_LOSE;
        else if (dealer > BLACKJACK)
            return RES_WIN;
        else if (player > dealer)
            return RES_WIN;
        else if (player < dealer)
            return RES_LOSE;
        else
            return RES_PUSH;
    endfunction

endpackage

// File: rtl/card_lfsr.sv
// Free-running 8-bit Fibonacci LFSR (taps 8,6,5,4) that offers a card whenever
// its low nibble is a legal rank; face cards collapse to 10.
module card_lfsr
    import deal_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
)
(
    input  logic       clk,
    input  logic       reset,
    output logic       cardValid,
    output logic [3:0] cardValue
);

    logic [7:0] lfsr;
    logic [3:0] rank;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            lfsr <= SEED;
        else
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end

    assign rank      = lfsr[3:0];
    assign cardValid = (rank != 4'd0) && (rank <= MAX_RANK);
    assign cardValue = (rank > FACE_VALUE) ? FACE_VALUE : rank;

endmodule

// File: rtl/deal_controller.sv
// Blackjack game sequencer: deals, runs player and dealer turns and resolves results,
// feeding one card at a time to the hand manager through a select/card/ack handshake.
module deal_controller
    import deal_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
)
(
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] hit,
    input  logic [1:0] stand,
    input  logic       cardsUpdated,
    input  logic [4:0] p1_high,
    input  logic [4:0] p1_low,
    input  logic [4:0] p2_high,
    input  logic [4:0] p2_low,
    input  logic [4:0] d_high,
    input  logic [4:0] d_low,
    output logic [1:0] userSelect,
    output logic [3:0] card,
    output logic       clearHands,
    output logic [2:0] phase,
    output logic [1:0] p1Result,
    output logic [1:0] p2Result
);

    phase_t     state, stateNext;
    xfer_t      xState, xNext;
    logic [2:0] dealIdx;
    logic [2:0] dealSlot;
    logic [1:0] xTarget;
    logic [1:0] xStartTarget;
    logic       xStart;
    logic       xIdle;
    logic       cardValid;
    logic [3:0] cardValue;
    logic [4:0] p1Best, p2Best, dBest;
    logic       p1Bust, p2Bust;

    card_lfsr #(.SEED(SEED)) u_lfsr (
        .clk       (clk),
        .reset     (reset),
        .cardValid (cardValid),
        .cardValue (cardValue)
    );

    assign p1Best     = best_total(p1_high, p1_low);
    assign p2Best     = best_total(p2_high, p2_low);
    assign dBest      = best_total(d_high, d_low);
    assign p1Bust     = p1Best > BLACKJACK;
    assign p2Bust     = p2Best > BLACKJACK;
    assign xIdle      = (xState == XIDLE);
    assign dealSlot   = (dealIdx >= 3'd3) ? dealIdx - 3'd3 : dealIdx;
    assign clearHands = (state == PH_CLEAR);
    assign phase      = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= PH_IDLE;
        else
            state <= stateNext;
    end

    // Decisions are only taken while the transfer engine is idle, so totals are settled
    // and any hit/stand pulse landing mid-transfer is simply dropped.
    always_comb begin
        stateNext    = state;
        xStart       = 1'b0;
        xStartTarget = SEL_NONE;
        case (state)
            PH_IDLE, PH_DONE: begin
                if (start)
                    stateNext = PH_CLEAR;
            end
            PH_CLEAR: stateNext = PH_DEAL;
            PH_DEAL: begin
                if (xIdle) begin
                    if (dealIdx == DEAL_CARDS) begin
                        stateNext = PH_P1;
                    end else if (!cardsUpdated) begin
                        xStart       = 1'b1;
                        xStartTarget = dealSlot[1:0] + 2'd1;
                    end
                end
            end
            PH_P1: begin
                if (xIdle) begin
                    if (stand[0] || (p1Best >= BLACKJACK)) begin
                        stateNext = PH_P2;
                    end else if (hit[0] && !cardsUpdated) begin
                        xStart       = 1'b1;
                        xStartTarget = SEL_P1;
                    end
                end
            end
            PH_P2: begin
                if (xIdle) begin
                    if (stand[1] || (p2Best >= BLACKJACK)) begin
                        stateNext = PH_DEALER;
                    end else if (hit[1] && !cardsUpdated) begin
                        xStart       = 1'b1;
                        xStartTarget = SEL_P2;
                    end
                end
            end
            PH_DEALER: begin
                if (xIdle) begin
                    if ((p1Bust && p2Bust) || (dBest >= DEALER_STAND)) begin
                        stateNext = PH_RESOLVE;
                    end else if (!cardsUpdated) begin
                        xStart       = 1'b1;
                        xStartTarget = SEL_DEALER;
                    end
                end
            end
            PH_RESOLVE: stateNext = PH_DONE;
            default:    stateNext = PH_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            dealIdx <= 3'd0;
        else if (state == PH_CLEAR)
            dealIdx <= 3'd0;
        else if ((state == PH_DEAL) && xStart)
            dealIdx <= dealIdx + 3'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p1Result <= RES_NONE;
            p2Result <= RES_NONE;
        end else if (((state == PH_IDLE) || (state == PH_DONE)) && start) begin
            p1Result <= RES_NONE;
            p2Result <= RES_NONE;
        end else if (state == PH_RESOLVE) begin
            p1Result <= resolve_hand(p1Best, dBest);
            p2Result <= resolve_hand(p2Best, dBest);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            xState <= XIDLE;
        else
            xState <= xNext;
    end

    always_comb begin
        xNext = xState;
        case (xState)
            XIDLE:   if (xStart)        xNext = XDRAW;
            XDRAW:   if (cardValid)     xNext = XHOLD;
            XHOLD:   if (cardsUpdated)  xNext = XDROP;
            XDROP:   if (!cardsUpdated) xNext = XSETTLE;
            XSETTLE:                    xNext = XIDLE;
            default:                    xNext = XIDLE;
        endcase
    end

    // Select and card are registered so they stay frozen for the whole hold phase.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            xTarget    <= SEL_NONE;
            userSelect <= SEL_NONE;
            card       <= 4'd0;
        end else begin
            if (xIdle && xStart)
                xTarget <= xStartTarget;
            if ((xState == XDRAW) && cardValid) begin
                userSelect <= xTarget;
                card       <= cardValue;
            end else if ((xState == XHOLD) && cardsUpdated) begin
                userSelect <= SEL_NONE;
                card       <= 4'd0;
            end
        end
    end

endmodule

// File: tb/tb_deal_controller.sv
// Self-checking bench for deal_controller: a hand-manager model keeps card sums per hand,
// directed games cover reset, dealing, arbitration and resolve, then random games follow.
module tb_deal_controller;

    logic       clk;
    logic       reset;
    logic       start;
    logic [1:0] hit;
    logic [1:0] stand;
    logic       cardsUpdated;
    logic [4:0] p1_high, p1_low, p2_high, p2_low, d_high, d_low;
    logic [1:0] userSelect;
    logic [3:0] card;
    logic       clearHands;
    logic [2:0] phase;
    logic [1:0] p1Result, p2Result;

    int  errors = 0;
    int  checks = 0;
    int  sum[3];
    bit  ace[3];
    bit  forceOnAck[3];
    int  forceSum[3];
    bit  ackEnable;
    bit  addCards;
    int  selQ[$];
    int  clrCount;
    int  firstSel;
    int  lastSel;
    int  lastCard;

    deal_controller #(.SEED(8'hA5)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .hit          (hit),
        .stand        (stand),
        .cardsUpdated (cardsUpdated),
        .p1_high      (p1_high),
        .p1_low       (p1_low),
        .p2_high      (p2_high),
        .p2_low       (p2_low),
        .d_high       (d_high),
        .d_low        (d_low),
        .userSelect   (userSelect),
        .card         (card),
        .clearHands   (clearHands),
        .phase        (phase),
        .p1Result     (p1Result),
        .p2Result     (p2Result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] hiOf(input int s, input bit a);
        int v;
        v = s + (a ? 10 : 0);
        if (v > 31) v = 31;
        return 5'(v);
    endfunction

    function automatic logic [4:0] loOf(input int s);
        int v;
        v = (s > 31) ? 31 : s;
        return 5'(v);
    endfunction

    assign p1_high = hiOf(sum[0], ace[0]);
    assign p1_low  = loOf(sum[0]);
    assign p2_high = hiOf(sum[1], ace[1]);
    assign p2_low  = loOf(sum[1]);
    assign d_high  = hiOf(sum[2], ace[2]);
    assign d_low   = loOf(sum[2]);

    function automatic int bestOf(input int h);
        int hi;
        hi = sum[h] + (ace[h] ? 10 : 0);
        return (hi <= 21) ? hi : sum[h];
    endfunction

    // Blackjack outcome: 1 win, 2 lose, 3 push.
    function automatic int expectRes(input int p, input int d);
        if (p > 21) return 2;
        if (d > 21) return 1;
        if (p > d)  return 1;
        if (p < d)  return 2;
        return 3;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Hand manager: acknowledges each card one sample after it appears and updates the sums.
    task automatic serviceManager();
        int h;
        if (reset) begin
            cardsUpdated = 1'b0;
            return;
        end
        if (clearHands) begin
            for (int i = 0; i < 3; i++) begin
                sum[i] = 0;
                ace[i] = 1'b0;
            end
        end
        if (ackEnable && (userSelect != 2'd0) && !cardsUpdated) begin
            h = int'(userSelect) - 1;
            checkOutput("card range", 32'((card >= 4'd1) && (card <= 4'd10)), 1);
            if ((phase == 3'd3) || (phase == 3'd4)) begin
                checkOutput("turn target", userSelect, int'(phase) - 2);
                checkOutput("hit below 21", 32'(bestOf(h) < 21), 1);
            end
            if (phase == 3'd5) begin
                checkOutput("dealer target", userSelect, 3);
                checkOutput("dealer below 17", 32'(bestOf(2) < 17), 1);
                checkOutput("dealer needed", 32'(!((bestOf(0) > 21) && (bestOf(1) > 21))), 1);
            end
            selQ.push_back(int'(userSelect));
            if (forceOnAck[h]) begin
                sum[h]        = forceSum[h];
                ace[h]        = 1'b0;
                forceOnAck[h] = 1'b0;
            end else if (addCards) begin
                sum[h] += int'(card);
                if (card == 4'd1) ace[h] = 1'b1;
            end
            cardsUpdated = 1'b1;
        end else if ((userSelect == 2'd0) && cardsUpdated) begin
            cardsUpdated = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        serviceManager();
        if (userSelect == 2'd0) begin
            checkOutput("idle card zero", card, 0);
        end else if (lastSel != 0) begin
            checkOutput("hold select stable", userSelect, lastSel);
            checkOutput("hold card stable", card, lastCard);
        end
        lastSel  = int'(userSelect);
        lastCard = int'(card);
    endtask

    task automatic applyStimulus(input logic s, input logic [1:0] h, input logic [1:0] st);
        start = s;
        hit   = h;
        stand = st;
        tick();
        start = 1'b0;
        hit   = 2'b00;
        stand = 2'b00;
    endtask

    task automatic runUntil(input string tag, input int target, input int budget);
        int n;
        n = 0;
        forever begin
            if (clearHands) clrCount++;
            if ((userSelect != 2'd0) && (firstSel < 0)) firstSel = n;
            if ((int'(phase) >= target) || (n >= budget)) break;
            tick();
            n++;
        end
        checkOutput({tag, " reached"}, 32'(int'(phase) >= target), 1);
    endtask

    task automatic checkResults(input string tag);
        checkOutput({tag, " p1Result"}, p1Result, expectRes(bestOf(0), bestOf(2)));
        checkOutput({tag, " p2Result"}, p2Result, expectRes(bestOf(1), bestOf(2)));
    endtask

    initial begin
        int n0;
        int saved;
        int idx;
        int b;
        logic [1:0] h;
        logic [1:0] s;

        reset = 1'b1;
        start = 1'b0;
        hit = 2'b00;
        stand = 2'b00;
        cardsUpdated = 1'b0;
        ackEnable = 1'b0;
        addCards = 1'b0;
        lastSel = 0;
        lastCard = 0;
        for (int i = 0; i < 3; i++) begin
            sum[i] = 0;
            ace[i] = 1'b0;
            forceOnAck[i] = 1'b0;
            forceSum[i] = 0;
        end
        repeat (3) tick();
        reset = 1'b0;
        checkOutput("reset outputs", {userSelect, card, clearHands, phase, p1Result, p2Result}, 0);

        // Reset while a card is held without acknowledge.
        applyStimulus(1'b1, 2'b00, 2'b00);
        n0 = 0;
        while ((userSelect == 2'd0) && (n0 < 40)) begin
            tick();
            n0++;
        end
        checkOutput("xhold select", userSelect, 1);
        saved = int'(card);
        repeat (3) tick();
        checkOutput("xhold no ack card", card, saved);
        #3 reset = 1'b1;
        #1;
        checkOutput("async reset select", userSelect, 0);
        checkOutput("async reset card", card, 0);
        checkOutput("async reset phase", phase, 0);
        checkOutput("async reset misc", {clearHands, p1Result, p2Result}, 0);
        #1 reset = 1'b0;
        lastSel = 0;
        tick();
        checkOutput("phase after release", phase, 0);

        // Game A: deal order, arbitration, dealer draws from 16.
        $display("[TB] game A");
        ackEnable = 1'b1;
        addCards = 1'b0;
        selQ.delete();
        clrCount = 0;
        firstSel = -1;
        applyStimulus(1'b1, 2'b00, 2'b00);
        runUntil("deal", 3, 300);
        checkOutput("deal phase", phase, 3);
        checkOutput("clearHands cycles", clrCount, 1);
        checkOutput("start latency ok", 32'(firstSel >= 3), 1);
        checkOutput("deal count", selQ.size(), 6);
        for (int i = 0; i < selQ.size(); i++)
            checkOutput("deal order", selQ[i], (i % 3) + 1);
        n0 = selQ.size();
        applyStimulus(1'b0, 2'b10, 2'b00);
        repeat (8) tick();
        checkOutput("p2 hit in p1 ignored", selQ.size(), n0);
        checkOutput("p2 hit phase", phase, 3);
        sum[0] = 12;
        applyStimulus(1'b0, 2'b01, 2'b01);
        repeat (8) tick();
        checkOutput("hit+stand no xfer", selQ.size(), n0);
        checkOutput("hit+stand phase", phase, 4);
        sum[1] = 18;
        sum[2] = 16;
        addCards = 1'b1;
        applyStimulus(1'b0, 2'b00, 2'b10);
        runUntil("game A done", 7, 200);
        checkOutput("game A phase", phase, 7);
        checkOutput("dealer 16 one card", selQ.size(), n0 + 1);
        checkOutput("dealer card target", selQ[$], 3);
        checkResults("game A");

        // Game B: restart from DONE, P1 busts, P2 holds 21, soft 17 dealer stands.
        $display("[TB] game B");
        addCards = 1'b0;
        applyStimulus(1'b1, 2'b00, 2'b00);
        checkOutput("restart phase", phase, 1);
        checkOutput("restart results", {p1Result, p2Result}, 0);
        runUntil("game B deal", 3, 300);
        sum[0] = 14;
        sum[1] = 21;
        sum[2] = 7;
        ace[2] = 1'b1;
        forceOnAck[0] = 1'b1;
        forceSum[0] = 24;
        n0 = selQ.size();
        applyStimulus(1'b0, 2'b01, 2'b00);
        runUntil("p1 bust", 4, 60);
        checkOutput("p1 bust phase", phase, 4);
        checkOutput("p1 hit one card", selQ.size(), n0 + 1);
        runUntil("p2 21 auto", 5, 2);
        checkOutput("p2 21 phase", phase, 5);
        runUntil("game B done", 7, 40);
        checkOutput("soft 17 no draw", selQ.size(), n0 + 1);
        checkOutput("game B p1 lose", p1Result, 2);
        checkResults("game B");

        // Game C: both players bust, dealer must not draw.
        $display("[TB] game C");
        applyStimulus(1'b1, 2'b00, 2'b00);
        runUntil("game C deal", 3, 300);
        sum[0] = 25;
        sum[1] = 22;
        n0 = selQ.size();
        runUntil("game C done", 7, 40);
        checkOutput("both bust no draw", selQ.size(), n0);
        checkResults("game C");

        // Game D: 20 / 18 against dealer 18.
        $display("[TB] game D");
        applyStimulus(1'b1, 2'b00, 2'b00);
        runUntil("game D deal", 3, 300);
        sum[0] = 20;
        sum[1] = 18;
        sum[2] = 18;
        n0 = selQ.size();
        applyStimulus(1'b0, 2'b00, 2'b01);
        runUntil("game D p2", 4, 10);
        checkOutput("game D p2 phase", phase, 4);
        applyStimulus(1'b0, 2'b00, 2'b10);
        runUntil("game D done", 7, 20);
        checkOutput("game D phase", phase, 7);
        checkOutput("game D no draw", selQ.size(), n0);
        checkOutput("game D p1 win", p1Result, 1);
        checkOutput("game D p2 push", p2Result, 3);

        // Random games with real card values feeding the sums.
        addCards = 1'b1;
        for (int g = 0; g < 6; g++) begin
            $display("[TB] random game %0d", g);
            applyStimulus(1'b1, 2'b00, 2'b00);
            runUntil("rg deal", 3, 300);
            n0 = 0;
            while (((phase == 3'd3) || (phase == 3'd4)) && (n0 < 120)) begin
                repeat ($urandom_range(0, 3)) tick();
                if ((phase == 3'd3) || (phase == 3'd4)) begin
                    idx = int'(phase) - 3;
                    b = bestOf(idx);
                    h = 2'b00;
                    s = 2'b00;
                    if ((b >= 17) || ($urandom_range(0, 4) == 0))
                        s[idx] = 1'b1;
                    else
                        h[idx] = 1'b1;
                    if ($urandom_range(0, 5) == 0)
                        h[1 - idx] = 1'b1;
                    applyStimulus(1'b0, h, s);
                end
                n0++;
            end
            runUntil("rg done", 7, 400);
            checkOutput("rg phase", phase, 7);
            checkResults("rg");
            if (!((bestOf(0) > 21) && (bestOf(1) > 21)))
                checkOutput("rg dealer stood", 32'(bestOf(2) >= 17), 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
